// File: rtl/pdm_modulator.sv
// PCM-to-PDM playback modulator: single-sample holding register, linear interpolator
// running at OSR bits per sample, and a saturating 2nd-order sigma-delta loop.
module pdm_modulator #(
  parameter int LOG2_OSR = 7,
  parameter int W        = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stb_bit,
  input  logic [15:0] pcm_in,
  input  logic        pcm_valid,
  output logic        pcm_ready,
  output logic        pdm_out,
  output logic        underrun
);

  localparam int AW = 16 + LOG2_OSR;
  localparam logic [LOG2_OSR-1:0] CNT_LAST = '1;
  localparam logic signed [W+1:0] SAT_MAX = {3'b000, {(W-1){1'b1}}};
  localparam logic signed [W+1:0] SAT_MIN = -SAT_MAX;
  localparam logic signed [W+1:0] FB_MAG  = (W+2)'(32768);

  logic [15:0]            hold;
  logic                   hold_full;
  logic signed [15:0]     tgt;
  logic signed [16:0]     delta;
  logic signed [AW-1:0]   acc;
  logic [LOG2_OSR-1:0]    bit_cnt;
  logic signed [W-1:0]    i1;
  logic signed [W-1:0]    i2;

  logic signed [15:0]     x;
  logic                   accept;
  logic                   boundary;
  logic signed [W+1:0]    fb;
  logic signed [W+1:0]    i1_sum;
  logic signed [W+1:0]    i2_sum;
  logic signed [W-1:0]    i1_new;
  logic signed [W-1:0]    i2_new;

  function automatic logic signed [W-1:0] sat(input logic signed [W+1:0] v);
    if (v > SAT_MAX)      return SAT_MAX[W-1:0];
    else if (v < SAT_MIN) return SAT_MIN[W-1:0];
    else                  return v[W-1:0];
  endfunction

  assign x         = acc[AW-1:LOG2_OSR];
  assign pcm_ready = !hold_full;
  assign accept    = pcm_valid && !hold_full;
  assign boundary  = stb_bit && (bit_cnt == CNT_LAST);

  // Loop math is done two bits wider than the integrators so the clamp sees the true sum.
  always_comb begin
    fb     = pdm_out ? FB_MAG : -FB_MAG;
    i1_sum = {{2{i1[W-1]}}, i1} + {{(W+2-16){x[15]}}, x} - fb;
    i1_new = sat(i1_sum);
    i2_sum = {{2{i2[W-1]}}, i2} + {{2{i1_new[W-1]}}, i1_new} - fb;
    i2_new = sat(i2_sum);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold      <= '0;
      hold_full <= 1'b0;
      tgt       <= '0;
      delta     <= '0;
      acc       <= '0;
      bit_cnt   <= '0;
      i1        <= '0;
      i2        <= '0;
      pdm_out   <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      underrun <= boundary && !hold_full;
      if (accept) begin
        hold      <= pcm_in;
        hold_full <= 1'b1;
      end
      if (stb_bit) begin
        bit_cnt <= bit_cnt + 1'b1;
        i1      <= i1_new;
        i2      <= i2_new;
        pdm_out <= !i2_new[W-1];
        if (bit_cnt == CNT_LAST) begin
          // Resync to the exact target so interpolation error never accumulates.
          acc <= {tgt, {LOG2_OSR{1'b0}}};
          if (hold_full) begin
            delta     <= {hold[15], hold} - {tgt[15], tgt};
            tgt       <= hold;
            hold_full <= 1'b0;
          end else begin
            delta <= '0;
          end
        end else begin
          acc <= acc + {{(AW-17){delta[16]}}, delta};
        end
      end
    end
  end

endmodule

// File: tb/tb_pdm_modulator.sv
// Directed bench for pdm_modulator: handshake, interpolation ramp, underrun, density and
// saturation scenarios with hand-computed expectations.
module tb_pdm_modulator;

  localparam int SMAX = 8388607;

  logic        clk = 1'b0;
  logic        rst;
  logic        stb_bit;
  logic [15:0] pcm_in;
  logic        pcm_valid;
  logic        pcm_ready;
  logic        pdm_out;
  logic        underrun;

  int errors = 0;
  int checks = 0;
  int nstb;
  int ones;
  int n_ur;
  int n_acc = 0;
  logic last_ur;

  logic signed [15:0] vals [5] = '{16'sd1000, -16'sd2000, 16'sd3000, -16'sd4000, 16'sd5000};

  pdm_modulator #(.LOG2_OSR(7), .W(24)) dut (
    .clk       (clk),
    .rst       (rst),
    .stb_bit   (stb_bit),
    .pcm_in    (pcm_in),
    .pcm_valid (pcm_valid),
    .pcm_ready (pcm_ready),
    .pdm_out   (pdm_out),
    .underrun  (underrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (!rst && pcm_valid && pcm_ready) n_acc <= n_acc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic do_reset();
    rst = 1'b1; stb_bit = 1'b0; pcm_valid = 1'b0; pcm_in = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    nstb = 0; ones = 0; n_ur = 0;
  endtask

  task automatic strobe();
    @(negedge clk);
    stb_bit = 1'b1;
    @(negedge clk);
    stb_bit = 1'b0;
    nstb++;
    last_ur = underrun;
    if (underrun) n_ur++;
    if (pdm_out) ones++;
  endtask

  task automatic strobe_n(input int n);
    for (int i = 0; i < n; i++) strobe();
  endtask

  task automatic test_reset();
    rst = 1'b1; stb_bit = 1'b0; pcm_valid = 1'b0; pcm_in = '0;
    @(negedge clk);
    checks++; if (pdm_out !== 1'b0)   begin errors++; $display("FAIL reset_pdm: got %b want 0", pdm_out); end
    checks++; if (pcm_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", pcm_ready); end
    checks++; if (underrun !== 1'b0)  begin errors++; $display("FAIL reset_underrun: got %b want 0", underrun); end
    checks++; if (dut.x !== 16'd0)    begin errors++; $display("FAIL reset_x: got %0d want 0", dut.x); end
    rst = 1'b0;
  endtask

  task automatic test_zero_density();
    do_reset();
    pcm_in = 16'd0; pcm_valid = 1'b1;
    strobe_n(1024);
    checks++; if (ones < 510 || ones > 514) begin errors++; $display("FAIL zero_density: got %0d ones want 512+/-2", ones); end
    checks++; if (n_ur !== 0) begin errors++; $display("FAIL zero_underrun: got %0d pulses want 0", n_ur); end
    pcm_valid = 1'b0;
  endtask

  task automatic test_const_density(input logic [15:0] v, input int want);
    do_reset();
    pcm_in = v; pcm_valid = 1'b1;
    strobe_n(256);
    ones = 0;
    strobe_n(256);
    checks++;
    if (ones < want - 2 || ones > want + 2) begin
      errors++; $display("FAIL const_density: input %0d got %0d ones want %0d+/-2", $signed(v), ones, want);
    end
    pcm_valid = 1'b0;
  endtask

  task automatic test_ramp();
    logic hold_pdm;
    do_reset();
    pcm_in = 16'd8192; pcm_valid = 1'b1;
    strobe_n(128);
    checks++; if (dut.x !== 16'd0) begin errors++; $display("FAIL ramp_start: got %0d want 0", dut.x); end
    for (int k = 1; k < 128; k++) begin
      strobe();
      checks++;
      if (dut.x !== 16'(64 * k)) begin errors++; $display("FAIL ramp_step: step %0d got %0d want %0d", k, dut.x, 64 * k); end
      if (k == 10) begin
        hold_pdm = pdm_out;
        repeat (4) @(negedge clk);
        checks++; if (pdm_out !== hold_pdm) begin errors++; $display("FAIL idle_pdm: got %b want %b", pdm_out, hold_pdm); end
        checks++; if (dut.x !== 16'd640) begin errors++; $display("FAIL idle_x: got %0d want 640", dut.x); end
      end
    end
    strobe();
    checks++; if (dut.x !== 16'd8192) begin errors++; $display("FAIL ramp_end_x: got %0d want 8192", dut.x); end
    checks++; if (dut.acc !== 23'(1048576)) begin errors++; $display("FAIL ramp_end_acc: got %0d want 1048576", dut.acc); end
    pcm_valid = 1'b0;
  endtask

  task automatic test_underrun();
    do_reset();
    pcm_in = 16'd4096; pcm_valid = 1'b1;
    @(negedge clk);
    pcm_valid = 1'b0;
    checks++; if (pcm_ready !== 1'b0) begin errors++; $display("FAIL ur_full: ready got %b want 0", pcm_ready); end
    strobe_n(255);
    checks++; if (n_ur !== 0) begin errors++; $display("FAIL ur_early: got %0d pulses want 0", n_ur); end
    checks++; if (pcm_ready !== 1'b1) begin errors++; $display("FAIL ur_consumed: ready got %b want 1", pcm_ready); end
    checks++; if (dut.x !== 16'd4064) begin errors++; $display("FAIL ur_ramp: x got %0d want 4064", dut.x); end
    strobe();
    checks++; if (last_ur !== 1'b1) begin errors++; $display("FAIL ur_pulse: got %b want 1", last_ur); end
    checks++; if (dut.x !== 16'd4096) begin errors++; $display("FAIL ur_x: got %0d want 4096", dut.x); end
    checks++; if (pcm_ready !== 1'b1) begin errors++; $display("FAIL ur_ready: got %b want 1", pcm_ready); end
    @(negedge clk);
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL ur_width: got %b want 0", underrun); end
    repeat (10) @(negedge clk);
    strobe_n(127);
    checks++; if (dut.x !== 16'd4096) begin errors++; $display("FAIL ur_frozen: x got %0d want 4096", dut.x); end
    @(negedge clk);
    stb_bit = 1'b1; pcm_valid = 1'b1; pcm_in = 16'hF000;
    @(negedge clk);
    stb_bit = 1'b0; pcm_valid = 1'b0; pcm_in = 16'h1234;
    nstb++;
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL ur_accept_pulse: got %b want 1", underrun); end
    checks++; if (pcm_ready !== 1'b0) begin errors++; $display("FAIL ur_accept_ready: got %b want 0", pcm_ready); end
    strobe_n(128);
    checks++; if (last_ur !== 1'b0) begin errors++; $display("FAIL ur_next_pulse: got %b want 0", last_ur); end
    checks++; if (pcm_ready !== 1'b1) begin errors++; $display("FAIL ur_next_ready: got %b want 1", pcm_ready); end
    checks++; if (dut.x !== 16'd4096) begin errors++; $display("FAIL ur_next_x: got %0d want 4096", dut.x); end
    strobe();
    checks++; if (dut.x !== 16'd4032) begin errors++; $display("FAIL ur_down1: x got %0d want 4032", dut.x); end
    strobe_n(63);
    checks++; if (dut.x !== 16'd0) begin errors++; $display("FAIL ur_down64: x got %0d want 0", dut.x); end
  endtask

  task automatic test_backpressure();
    int a0;
    int idx;
    int m;
    logic chk;
    logic signed [15:0] exp_x;
    do_reset();
    a0 = n_acc;
    pcm_in = vals[0]; pcm_valid = 1'b1; chk = 1'b0;
    for (int cyc = 0; cyc < 1040; cyc++) begin
      @(negedge clk);
      stb_bit = 1'b0;
      if (chk) begin
        m = nstb / 128;
        exp_x = (m >= 2) ? vals[m-2] : 16'sd0;
        checks++; if (dut.x !== exp_x) begin errors++; $display("FAIL bp_x: boundary %0d got %0d want %0d", m, dut.x, exp_x); end
        checks++; if (pcm_ready !== 1'b1) begin errors++; $display("FAIL bp_ready: boundary %0d got %b want 1", m, pcm_ready); end
        chk = 1'b0;
      end
      idx = n_acc - a0;
      pcm_in = (pcm_ready && idx < 5) ? vals[idx] : 16'($urandom);
      if (cyc % 2 == 1 && nstb < 512) begin
        stb_bit = 1'b1;
        nstb++;
        chk = (nstb % 128 == 0);
      end
    end
    repeat (3) @(negedge clk);
    checks++; if (n_acc - a0 !== 5) begin errors++; $display("FAIL bp_accepts: got %0d want 5", n_acc - a0); end
    pcm_valid = 1'b0;
  endtask

  task automatic test_saturation_and_reset();
    int bad;
    do_reset();
    pcm_in = 16'h7FFF; pcm_valid = 1'b1;
    strobe_n(256);
    ones = 0; bad = 0;
    for (int i = 0; i < 4096; i++) begin
      strobe();
      if (int'(dut.i1) < -SMAX || int'(dut.i1) > SMAX || int'(dut.i2) < -SMAX || int'(dut.i2) > SMAX) bad++;
    end
    checks++; if (ones * 100 < 95 * 4096) begin errors++; $display("FAIL sat_density: got %0d ones of 4096 want >= 3892", ones); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL sat_bounds: got %0d out-of-range steps want 0", bad); end
    strobe_n(40);
    checks++; if (pcm_ready !== 1'b0) begin errors++; $display("FAIL pre_reset_ready: got %b want 0", pcm_ready); end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (pdm_out !== 1'b0)   begin errors++; $display("FAIL mid_reset_pdm: got %b want 0", pdm_out); end
    checks++; if (pcm_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_ready: got %b want 1", pcm_ready); end
    checks++; if (underrun !== 1'b0)  begin errors++; $display("FAIL mid_reset_underrun: got %b want 0", underrun); end
    checks++; if (dut.x !== 16'd0)    begin errors++; $display("FAIL mid_reset_x: got %0d want 0", dut.x); end
    checks++; if (dut.i2 !== 24'd0)   begin errors++; $display("FAIL mid_reset_i2: got %0d want 0", dut.i2); end
    @(negedge clk);
    rst = 1'b0; pcm_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_zero_density();
    test_const_density(16'h4000, 192);
    test_const_density(16'hC000, 64);
    test_ramp();
    test_underrun();
    test_backpressure();
    test_saturation_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
